// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: ROM word layout, octave codes,
// FSM state encoding and the note decoder.
package song_pkg;

    localparam int WORD_W   = 9;
    localparam int NOTE_LSB = 0;
    localparam int NOTE_W   = 3;
    localparam int OCT_LSB  = 3;
    localparam int OCT_W    = 2;
    localparam int DUR_LSB  = 5;
    localparam int DUR_FW   = 4;
    localparam int NOTES_W  = 7;

    typedef enum logic [1:0] {
        OCT_MID  = 2'b00,
        OCT_HIGH = 2'b01,
        OCT_LOW  = 2'b10,
        OCT_END  = 2'b11
    } octave_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_NOTE,
        ST_GAP,
        ST_DONE
    } state_e;

    // Note 1 (do) maps to bit 6, note 7 (si) to bit 0; 0 is a rest.
    function automatic logic [NOTES_W-1:0] note_to_onehot(input logic [NOTE_W-1:0] note);
        logic [NOTES_W-1:0] oh;
        case (note)
            3'd1:    oh = 7'b1000000;
            3'd2:    oh = 7'b0100000;
            3'd3:    oh = 7'b0010000;
            3'd4:    oh = 7'b0001000;
            3'd5:    oh = 7'b0000100;
            3'd6:    oh = 7'b0000010;
            3'd7:    oh = 7'b0000001;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Song ROM bus: the sequencer drives the address, the ROM returns the word
// one clock later.
interface song_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] rom_addr;
    logic [8:0]        rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/song_sequencer_beat_timer.sv
// Beat timer: cycle counter wrapping every BEAT_CYCLES and a beat-unit counter.
// Both freeze while i_en is low and return to zero on i_clr.
module beat_timer
    import song_pkg::*;
#(
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int DUR_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DUR_W-1:0] i_last_unit,
    output logic             o_tick,
    output logic             o_gap_start,
    output logic             o_end
);

    localparam int                CYC_W    = $clog2(BEAT_CYCLES);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BEAT_CYCLES - 1);
    // Flag is raised on the last sounding cycle so the FSM is in GAP exactly
    // when the count reaches BEAT_CYCLES-GAP_CYCLES of the final unit.
    localparam logic [CYC_W-1:0] CYC_GAP  = CYC_W'(BEAT_CYCLES - GAP_CYCLES - 1);

    logic [CYC_W-1:0] r_cyc;
    logic [DUR_W-1:0] r_unit;
    logic             w_last_unit;

    assign w_last_unit = (r_unit == i_last_unit);
    assign o_tick      = i_en && (r_cyc == CYC_LAST);
    assign o_gap_start = i_en && w_last_unit && (r_cyc == CYC_GAP);
    assign o_end       = o_tick && w_last_unit;

    // Cycle and unit counters with freeze and clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc  <= '0;
            r_unit <= '0;
        end else if (i_clr) begin
            r_cyc  <= '0;
            r_unit <= '0;
        end else if (i_en) begin
            if (r_cyc == CYC_LAST) begin
                r_cyc  <= '0;
                r_unit <= r_unit + DUR_W'(1);
            end else begin
                r_cyc <= r_cyc + CYC_W'(1);
            end
        end
    end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: plays note words from a synchronous song ROM into the tone
// generator, with a silent gap after each note; passes free-play keys when idle.
module song_sequencer
    import song_pkg::*;
#(
    parameter int ADDR_W      = 6,
    parameter int DUR_W       = 4,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_000_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic                 i_stop,
    input  logic                 i_pause,
    song_sequencer_if.master     rom,
    input  logic [NOTES_W-1:0]   i_key_notes,
    input  logic                 i_key_higher,
    input  logic                 i_key_lower,
    output logic [NOTES_W-1:0]   o_notes,
    output logic                 o_ishigher,
    output logic                 o_islower,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [ADDR_W-1:0]   w_rom_addr_nxt;

    logic [NOTE_W-1:0]   r_note;
    octave_e             r_oct;
    logic [DUR_W-1:0]    r_last_unit;

    logic [NOTES_W-1:0]  r_notes;
    logic                r_ishigher;
    logic                r_islower;
    logic                r_busy;
    logic                r_done;
    logic [NOTES_W-1:0]  w_notes_nxt;
    logic                w_ishigher_nxt;
    logic                w_islower_nxt;

    logic [NOTE_W-1:0]   w_word_note;
    octave_e             w_word_oct;
    logic [DUR_FW-1:0]   w_word_dur;
    logic [DUR_FW-1:0]   w_word_dur_m1;

    logic                w_tmr_en;
    logic                w_tmr_clr;
    logic                w_tick;
    logic                w_gap_start;
    logic                w_end;

    assign w_word_note   = rom.rom_data[NOTE_LSB +: NOTE_W];
    assign w_word_oct    = octave_e'(rom.rom_data[OCT_LSB +: OCT_W]);
    assign w_word_dur    = rom.rom_data[DUR_LSB +: DUR_FW];
    // A zero duration plays as one beat unit.
    assign w_word_dur_m1 = (w_word_dur == '0) ? '0 : w_word_dur - DUR_FW'(1);

    assign w_tmr_en  = !i_pause && ((r_state == ST_NOTE) || (r_state == ST_GAP));
    assign w_tmr_clr = !((r_state == ST_NOTE) || (r_state == ST_GAP));

    beat_timer #(
        .BEAT_CYCLES (BEAT_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .DUR_W       (DUR_W)
    ) u_beat_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (w_tmr_en),
        .i_clr       (w_tmr_clr),
        .i_last_unit (r_last_unit),
        .o_tick      (w_tick),
        .o_gap_start (w_gap_start),
        .o_end       (w_end)
    );

    // Next state and next ROM address.
    always_comb begin
        w_state_nxt    = r_state;
        w_rom_addr_nxt = r_rom_addr;
        if ((r_state != ST_IDLE) && i_stop) begin
            w_state_nxt    = ST_IDLE;
            w_rom_addr_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start && !i_stop) begin
                        w_state_nxt    = ST_FETCH;
                        w_rom_addr_nxt = '0;
                    end
                end
                ST_FETCH: w_state_nxt = ST_LOAD;
                ST_LOAD: begin
                    if (w_word_oct == OCT_END) w_state_nxt = ST_DONE;
                    else                       w_state_nxt = ST_NOTE;
                end
                ST_NOTE: begin
                    if (w_gap_start) w_state_nxt = ST_GAP;
                end
                ST_GAP: begin
                    if (w_end) begin
                        if (r_rom_addr == ADDR_LAST) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_state_nxt    = ST_FETCH;
                            w_rom_addr_nxt = r_rom_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output mux, evaluated for the state being entered so outputs can be registered.
    always_comb begin
        w_notes_nxt    = '0;
        w_ishigher_nxt = 1'b0;
        w_islower_nxt  = 1'b0;
        case (w_state_nxt)
            ST_IDLE: begin
                if (r_state == ST_IDLE) begin
                    w_notes_nxt    = i_key_notes;
                    w_ishigher_nxt = i_key_higher;
                    w_islower_nxt  = i_key_lower;
                end
            end
            ST_NOTE: begin
                if (r_state == ST_LOAD) begin
                    w_notes_nxt    = note_to_onehot(w_word_note);
                    w_ishigher_nxt = (w_word_oct == OCT_HIGH);
                    w_islower_nxt  = (w_word_oct == OCT_LOW);
                end else if (!i_pause) begin
                    w_notes_nxt    = note_to_onehot(r_note);
                    w_ishigher_nxt = (r_oct == OCT_HIGH);
                    w_islower_nxt  = (r_oct == OCT_LOW);
                end
            end
            default: ;
        endcase
    end

    // State and ROM address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_rom_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rom_addr <= w_rom_addr_nxt;
        end
    end

    // Latch the fields of the word being played.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_note      <= '0;
            r_oct       <= OCT_MID;
            r_last_unit <= '0;
        end else if (r_state == ST_LOAD) begin
            r_note      <= w_word_note;
            r_oct       <= w_word_oct;
            r_last_unit <= DUR_W'(w_word_dur_m1);
        end
    end

    // Registered outputs to the tone generator and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_notes    <= '0;
            r_ishigher <= 1'b0;
            r_islower  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_notes    <= w_notes_nxt;
            r_ishigher <= w_ishigher_nxt;
            r_islower  <= w_islower_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_done     <= (w_state_nxt == ST_DONE);
        end
    end

    assign rom.rom_addr = r_rom_addr;
    assign o_notes      = r_notes;
    assign o_ishigher   = r_ishigher;
    assign o_islower    = r_islower;
    assign o_busy       = r_busy;
    assign o_done       = r_done;

endmodule
